// File: rtl/reset_seq_wdt_if.sv
// Bus bundle for reset_seq_wdt: lock/request/watchdog inputs and the
// sequenced reset, status and cause outputs.
//   master : drives pll_locked, sw_reset_req, wdt_enable, wdt_kick, cause_clear
//   slave  : drives dom_rst_n, seq_done, wdt_warn, wdt_expired, wdt_chan, reset_cause
interface reset_seq_wdt_if #(
  parameter int unsigned N_DOMAINS = 4,
  parameter int unsigned N_WDT     = 2
);
  logic                 pll_locked;
  logic                 sw_reset_req;
  logic [N_WDT-1:0]     wdt_enable;
  logic [N_WDT-1:0]     wdt_kick;
  logic                 cause_clear;
  logic [N_DOMAINS-1:0] dom_rst_n;
  logic                 seq_done;
  logic [N_WDT-1:0]     wdt_warn;
  logic                 wdt_expired;
  logic [1:0]           wdt_chan;
  logic [4:0]           reset_cause;

  modport master (
    output pll_locked, sw_reset_req, wdt_enable, wdt_kick, cause_clear,
    input  dom_rst_n, seq_done, wdt_warn, wdt_expired, wdt_chan, reset_cause
  );

  modport slave (
    input  pll_locked, sw_reset_req, wdt_enable, wdt_kick, cause_clear,
    output dom_rst_n, seq_done, wdt_warn, wdt_expired, wdt_chan, reset_cause
  );
endinterface

// File: rtl/reset_seq_wdt.sv
// Reset sequencer plus multi-channel windowed watchdog (clk_sys domain).
// Waits for pll_locked to be stable, releases dom_rst_n[0..N-1] in order
// with STAGE_GAP spacing, then supervises N_WDT watchdogs. Lock loss, a
// software request or a watchdog fault forces all domain resets low for
// RST_PULSE cycles and restarts the sequence. Causes are kept sticky.
// Ports:
//   clk_sys   : system clock
//   rst_sys_n : asynchronous active-low reset
//   bus       : reset_seq_wdt_if slave (inputs: lock/requests/kicks,
//               outputs: dom_rst_n, seq_done, wdt_warn, wdt_expired,
//               wdt_chan, reset_cause)
module reset_seq_wdt #(
  parameter int unsigned N_DOMAINS   = 4,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned LOCK_STABLE = 8,
  parameter int unsigned RST_PULSE   = 4,
  parameter int unsigned N_WDT       = 2,
  parameter int unsigned WDT_TIMEOUT = 100,
  parameter int unsigned WDT_WARN    = 80,
  parameter int unsigned WDT_WIN_MIN = 0
) (
  input  logic           clk_sys,
  input  logic           rst_sys_n,
  reset_seq_wdt_if.slave bus
);
  localparam int unsigned LW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned GW = $clog2(STAGE_GAP + 1);
  localparam int unsigned PW = $clog2(RST_PULSE + 1);
  localparam int unsigned TW = $clog2(WDT_TIMEOUT + 1);
  localparam int unsigned DW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_STABLE - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
  localparam logic [TW-1:0] WDT_LAST   = TW'(WDT_TIMEOUT - 1);
  localparam logic [TW-1:0] WARN_C     = TW'(WDT_WARN);
  localparam logic [TW:0]   WIN_MIN_X  = (TW+1)'(WDT_WIN_MIN);
  localparam logic [TW:0]   ONE_X      = (TW+1)'(1);
  localparam logic [DW-1:0] DOM_LAST   = DW'(N_DOMAINS - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, FAULT} state_t;

  state_t                     state_q, state_d;
  logic [LW-1:0]              lock_cnt_q, lock_cnt_d;
  logic [GW-1:0]              gap_cnt_q, gap_cnt_d;
  logic [PW-1:0]              pulse_cnt_q, pulse_cnt_d;
  logic [DW-1:0]              dom_idx_q, dom_idx_d;
  logic [N_WDT-1:0][TW-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic [N_DOMAINS-1:0]       dom_rst_n_q, dom_rst_n_d;
  logic                       seq_done_q, seq_done_d;
  logic [N_WDT-1:0]           wdt_warn_q, wdt_warn_d;
  logic                       wdt_expired_q, wdt_expired_d;
  logic [1:0]                 wdt_chan_q, wdt_chan_d;
  logic [4:0]                 reset_cause_q, reset_cause_d;

  logic [N_WDT-1:0] early, timeout;
  logic [1:0]       chan_sel;
  logic [4:0]       cause_set;
  logic             trigger;

  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    pulse_cnt_d   = pulse_cnt_q;
    dom_idx_d     = dom_idx_q;
    dom_rst_n_d   = dom_rst_n_q;
    seq_done_d    = seq_done_q;
    wdt_expired_d = 1'b0;
    wdt_chan_d    = wdt_chan_q;
    wdt_warn_d    = '0;
    wdt_cnt_d     = '0;
    early         = '0;
    timeout       = '0;
    cause_set     = '0;
    chan_sel      = '0;

    // Watchdogs only advance in RUN; everywhere else they sit at zero.
    if (state_q == RUN) begin
      for (int unsigned i = 0; i < N_WDT; i++) begin
        if (bus.wdt_enable[i]) begin
          if (bus.wdt_kick[i]) begin
            // counter < WDT_WIN_MIN, phrased so a zero window folds to false
            if (({1'b0, wdt_cnt_q[i]} + ONE_X) <= WIN_MIN_X) early[i] = 1'b1;
          end else if (wdt_cnt_q[i] == WDT_LAST) begin
            timeout[i] = 1'b1;
          end else begin
            wdt_cnt_d[i] = wdt_cnt_q[i] + TW'(1);
          end
        end
      end
    end

    for (int unsigned i = N_WDT; i > 0; i--) begin
      if (early[i-1] || timeout[i-1]) chan_sel = 2'(i - 1);
    end

    trigger = !bus.pll_locked || bus.sw_reset_req || (|early) || (|timeout);

    case (state_q)
      HOLD: begin
        if (!bus.pll_locked) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          lock_cnt_d     = '0;
          gap_cnt_d      = '0;
          dom_idx_d      = DW'(1);
          dom_rst_n_d[0] = 1'b1;
          if (N_DOMAINS == 1) begin
            state_d    = RUN;
            seq_done_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      RELEASE, RUN: begin
        if (trigger) begin
          state_d     = FAULT;
          pulse_cnt_d = '0;
          dom_rst_n_d = '0;
          seq_done_d  = 1'b0;
          cause_set   = {|early, |timeout, bus.sw_reset_req, !bus.pll_locked, 1'b0};
          if ((|early) || (|timeout)) begin
            wdt_expired_d = 1'b1;
            wdt_chan_d    = chan_sel;
          end
        end else if (state_q == RELEASE) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d              = '0;
            dom_rst_n_d[dom_idx_q] = 1'b1;
            dom_idx_d              = dom_idx_q + DW'(1);
            if (dom_idx_q == DOM_LAST) begin
              state_d    = RUN;
              seq_done_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end
      FAULT: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d     = HOLD;
          pulse_cnt_d = '0;
          lock_cnt_d  = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
      default: state_d = HOLD;
    endcase

    for (int unsigned i = 0; i < N_WDT; i++) begin
      wdt_warn_d[i] = (state_d == RUN) && (wdt_cnt_d[i] >= WARN_C);
    end

    // A cause raised this cycle survives a simultaneous clear.
    reset_cause_d = (bus.cause_clear ? 5'b00000 : reset_cause_q) | cause_set;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q       <= HOLD;
      lock_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      pulse_cnt_q   <= '0;
      dom_idx_q     <= '0;
      wdt_cnt_q     <= '0;
      dom_rst_n_q   <= '0;
      seq_done_q    <= 1'b0;
      wdt_warn_q    <= '0;
      wdt_expired_q <= 1'b0;
      wdt_chan_q    <= '0;
      reset_cause_q <= 5'b00001;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      dom_idx_q     <= dom_idx_d;
      wdt_cnt_q     <= wdt_cnt_d;
      dom_rst_n_q   <= dom_rst_n_d;
      seq_done_q    <= seq_done_d;
      wdt_warn_q    <= wdt_warn_d;
      wdt_expired_q <= wdt_expired_d;
      wdt_chan_q    <= wdt_chan_d;
      reset_cause_q <= reset_cause_d;
    end
  end

  assign bus.dom_rst_n   = dom_rst_n_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.wdt_warn    = wdt_warn_q;
  assign bus.wdt_expired = wdt_expired_q;
  assign bus.wdt_chan    = wdt_chan_q;
  assign bus.reset_cause = reset_cause_q;
endmodule
